// File: rtl/timebase_pkg.sv
// rtl/timebase_pkg.sv - shared timebase types and constants for the gate scheduler
package timebase_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        GATE  = 2'd2
    } state_t;

    localparam int CLK_HZ       = 9600000;
    localparam int TICKS_PER_MS = CLK_HZ / 1000;

    localparam int GATE_W_DEF = 16;
    localparam int ID_W_DEF   = 16;

endpackage

// File: rtl/gate_scheduler_if.sv
// rtl/gate_scheduler_if.sv - report handshake from the gate scheduler to the output serializer
interface gate_scheduler_if #(
    parameter int ID_W = timebase_pkg::ID_W_DEF
);
    logic            report_req;
    logic            report_ack;
    logic [ID_W-1:0] report_id;

    modport master (
        output report_req,
        output report_id,
        input  report_ack
    );

    modport slave (
        input  report_req,
        input  report_id,
        output report_ack
    );
endinterface

// File: rtl/report_slot.sv
// rtl/report_slot.sv - single-entry req/ack holding register with overwrite detection
module report_slot #(
    parameter int ID_W = timebase_pkg::ID_W_DEF
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            load,
    input  logic [ID_W-1:0] load_id,
    input  logic            clr_overrun,
    output logic            report_req,
    input  logic            report_ack,
    output logic [ID_W-1:0] report_id,
    output logic            overrun
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            report_req <= 1'b0;
            report_id  <= '0;
            overrun    <= 1'b0;
        end else begin
            // A new load always wins; an ack in the same cycle retires the old entry.
            if (load) begin
                report_req <= 1'b1;
                report_id  <= load_id;
            end else if (report_req && report_ack) begin
                report_req <= 1'b0;
            end

            if (load && report_req && !report_ack) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gate_scheduler.sv
// rtl/gate_scheduler.sv - back-to-back ms-gated counting windows with clear/latch strobes and report handoff
module gate_scheduler
    import timebase_pkg::*;
#(
    parameter int GATE_W = GATE_W_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ms_tick,
    input  logic              enable,
    input  logic [GATE_W-1:0] gate_ms,
    output logic              gate_open,
    output logic              clear,
    output logic              latch,
    output logic [ID_W-1:0]   window_id,
    output logic              overrun,
    gate_scheduler_if.master  rpt
);

    state_t            state, state_n;
    logic              gate_open_n, clear_n, latch_n;
    logic [ID_W-1:0]   window_id_n;
    logic [ID_W-1:0]   closed_id, closed_id_n;
    logic [GATE_W-1:0] ms_cnt, ms_cnt_n;
    logic [GATE_W-1:0] gate_len, gate_len_n;
    logic [GATE_W-1:0] gate_ms_eff;
    logic              enable_d;
    logic              enable_rise;

    assign gate_ms_eff = (gate_ms == '0) ? GATE_W'(1) : gate_ms;
    assign enable_rise = enable && !enable_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            gate_open <= 1'b0;
            clear     <= 1'b0;
            latch     <= 1'b0;
            window_id <= '0;
            closed_id <= '0;
            ms_cnt    <= '0;
            gate_len  <= GATE_W'(1);
            enable_d  <= 1'b0;
        end else begin
            state     <= state_n;
            gate_open <= gate_open_n;
            clear     <= clear_n;
            latch     <= latch_n;
            window_id <= window_id_n;
            closed_id <= closed_id_n;
            ms_cnt    <= ms_cnt_n;
            gate_len  <= gate_len_n;
            enable_d  <= enable;
        end
    end

    always_comb begin
        state_n     = state;
        gate_open_n = gate_open;
        clear_n     = 1'b0;
        latch_n     = 1'b0;
        window_id_n = window_id;
        closed_id_n = closed_id;
        ms_cnt_n    = ms_cnt;
        gate_len_n  = gate_len;

        case (state)
            IDLE: begin
                gate_open_n = 1'b0;
                if (enable) begin
                    state_n = ALIGN;
                end
            end
            ALIGN: begin
                if (!enable) begin
                    state_n     = IDLE;
                    gate_open_n = 1'b0;
                end else if (ms_tick) begin
                    state_n     = GATE;
                    clear_n     = 1'b1;
                    gate_open_n = 1'b1;
                    gate_len_n  = gate_ms_eff;
                    ms_cnt_n    = '0;
                end
            end
            GATE: begin
                // Stop beats a coinciding tick: the partial window is dropped silently.
                if (!enable) begin
                    state_n     = IDLE;
                    gate_open_n = 1'b0;
                    ms_cnt_n    = '0;
                end else if (ms_tick) begin
                    if (ms_cnt == gate_len - GATE_W'(1)) begin
                        latch_n     = 1'b1;
                        clear_n     = 1'b1;
                        closed_id_n = window_id;
                        window_id_n = window_id + ID_W'(1);
                        ms_cnt_n    = '0;
                        gate_len_n  = gate_ms_eff;
                    end else begin
                        ms_cnt_n = ms_cnt + GATE_W'(1);
                    end
                end
            end
            default: begin
                state_n     = IDLE;
                gate_open_n = 1'b0;
            end
        endcase
    end

    // The slot loads from the registered latch so report_req trails the latch strobe by one cycle.
    report_slot #(
        .ID_W (ID_W)
    ) u_report_slot (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .load        (latch),
        .load_id     (closed_id),
        .clr_overrun (enable_rise),
        .report_req  (rpt.report_req),
        .report_ack  (rpt.report_ack),
        .report_id   (rpt.report_id),
        .overrun     (overrun)
    );

endmodule

// File: tb/tb_gate_scheduler.sv
// tb/tb_gate_scheduler.sv - self-checking bench for gate_scheduler
module tb_gate_scheduler;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ms_tick = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] gate_ms = 16'd3;
    logic        gate_open, clear, latch, overrun;
    logic [15:0] window_id;

    gate_scheduler_if rif ();

    gate_scheduler dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ms_tick   (ms_tick),
        .enable    (enable),
        .gate_ms   (gate_ms),
        .gate_open (gate_open),
        .clear     (clear),
        .latch     (latch),
        .window_id (window_id),
        .overrun   (overrun),
        .rpt       (rif)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          c;
        logic [15:0] id;
    } exp_t;
    exp_t sb[$];

    // Every latch must match the oldest predicted window end in cycle and new window_id.
    always @(negedge CLK) begin
        if (latch === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_latch cyc=%0d window_id=%0d required no latch", cyc, window_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc !== e.c || window_id !== e.id || clear !== 1'b1) begin
                    fails++;
                    $display("FAIL latch_event got cyc=%0d id=%0d clear=%b required cyc=%0d id=%0d clear=1",
                             cyc, window_id, clear, e.c, e.id);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic tick();
        ms_tick = 1'b1;
        step();
        ms_tick = 1'b0;
    endtask

    task automatic run_window(input int n, input int period, input logic [15:0] id_after);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            idle(period - 1);
            if (i == n - 1) begin
                e.c  = cyc + 1;
                e.id = id_after;
                sb.push_back(e);
            end
            tick();
        end
    endtask

    task automatic do_reset();
        RST_N          = 1'b0;
        enable         = 1'b0;
        ms_tick        = 1'b0;
        rif.report_ack = 1'b0;
        gate_ms        = 16'd3;
        idle(2);
        RST_N = 1'b1;
        step();
    endtask

    task automatic open_window(input int period, input logic [15:0] id);
        enable = 1'b1;
        step();
        idle(period - 1);
        tick();
        tests++;
        if (clear !== 1'b1 || gate_open !== 1'b1 || latch !== 1'b0 || window_id !== id) begin
            fails++;
            $display("FAIL window_open got clear=%b open=%b latch=%b id=%0d required 1 1 0 %0d",
                     clear, gate_open, latch, window_id, id);
        end
    endtask

    task automatic sb_drained(input string name);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_missing_latches got %0d pending required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        idle(3);
        tests++;
        if (gate_open !== 1'b0 || clear !== 1'b0 || latch !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes got open=%b clear=%b latch=%b ovr=%b required all 0",
                     gate_open, clear, latch, overrun);
        end
        tests++;
        if (window_id !== 16'd0 || rif.report_req !== 1'b0 || rif.report_id !== 16'd0) begin
            fails++;
            $display("FAIL reset_ids got id=%0d req=%b rid=%0d required 0 0 0",
                     window_id, rif.report_req, rif.report_id);
        end
    endtask

    task automatic test_basic();
        do_reset();
        gate_ms        = 16'd3;
        rif.report_ack = 1'b1;
        open_window(10, 16'd0);
        for (int w = 1; w <= 3; w++) begin
            run_window(3, 10, 16'(w));
            tests++;
            if (gate_open !== 1'b1) begin
                fails++;
                $display("FAIL basic_gate_open w=%0d got %b required 1", w, gate_open);
            end
            step();
            tests++;
            if (rif.report_req !== 1'b1 || rif.report_id !== 16'(w - 1) || gate_open !== 1'b1) begin
                fails++;
                $display("FAIL basic_report w=%0d got req=%b rid=%0d open=%b required 1 %0d 1",
                         w, rif.report_req, rif.report_id, gate_open, w - 1);
            end
        end
        idle(2);
        sb_drained("basic");
    endtask

    task automatic test_gate_zero();
        do_reset();
        gate_ms        = 16'd0;
        rif.report_ack = 1'b1;
        open_window(4, 16'd0);
        for (int w = 1; w <= 4; w++) run_window(1, 4, 16'(w));
        idle(2);
        sb_drained("gate_zero");
    endtask

    task automatic test_gate_change();
        do_reset();
        gate_ms = 16'd3;
        open_window(6, 16'd0);
        gate_ms = 16'd5;
        run_window(3, 6, 16'd1);
        run_window(5, 6, 16'd2);
        run_window(5, 6, 16'd3);
        idle(2);
        sb_drained("gate_change");
    endtask

    task automatic test_overrun();
        do_reset();
        gate_ms = 16'd2;
        open_window(4, 16'd0);
        run_window(2, 4, 16'd1);
        step();
        tests++;
        if (rif.report_req !== 1'b1 || rif.report_id !== 16'd0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_first got req=%b rid=%0d ovr=%b required 1 0 0",
                     rif.report_req, rif.report_id, overrun);
        end
        run_window(2, 4, 16'd2);
        step();
        tests++;
        if (rif.report_req !== 1'b1 || rif.report_id !== 16'd1 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_second got req=%b rid=%0d ovr=%b required 1 1 1",
                     rif.report_req, rif.report_id, overrun);
        end
        rif.report_ack = 1'b1;
        step();
        rif.report_ack = 1'b0;
        tests++;
        if (rif.report_req !== 1'b0 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_ack got req=%b ovr=%b required 0 1", rif.report_req, overrun);
        end
        rif.report_ack = 1'b1;
        step();
        rif.report_ack = 1'b0;
        tests++;
        if (rif.report_req !== 1'b0 || rif.report_id !== 16'd1) begin
            fails++;
            $display("FAIL idle_ack got req=%b rid=%0d required 0 1", rif.report_req, rif.report_id);
        end
        sb_drained("overrun");
    endtask

    task automatic test_ack_with_latch();
        do_reset();
        gate_ms = 16'd1;
        open_window(4, 16'd0);
        run_window(1, 4, 16'd1);
        step();
        tests++;
        if (rif.report_req !== 1'b1 || rif.report_id !== 16'd0) begin
            fails++;
            $display("FAIL ackl_first got req=%b rid=%0d required 1 0", rif.report_req, rif.report_id);
        end
        run_window(1, 4, 16'd2);
        rif.report_ack = 1'b1;
        step();
        rif.report_ack = 1'b0;
        tests++;
        if (rif.report_req !== 1'b1 || rif.report_id !== 16'd1 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL ackl_same got req=%b rid=%0d ovr=%b required 1 1 0",
                     rif.report_req, rif.report_id, overrun);
        end
        step();
        tests++;
        if (rif.report_req !== 1'b1) begin
            fails++;
            $display("FAIL ackl_pending got req=%b required 1", rif.report_req);
        end
        sb_drained("ack_latch");
    endtask

    task automatic test_stop_on_tick();
        do_reset();
        gate_ms = 16'd1;
        open_window(4, 16'd0);
        run_window(1, 4, 16'd1);
        idle(3);
        enable  = 1'b0;
        ms_tick = 1'b1;
        step();
        ms_tick = 1'b0;
        tests++;
        if (latch !== 1'b0 || clear !== 1'b0 || gate_open !== 1'b0 || window_id !== 16'd1) begin
            fails++;
            $display("FAIL stop_tick got latch=%b clear=%b open=%b id=%0d required 0 0 0 1",
                     latch, clear, gate_open, window_id);
        end
        idle(2);
        sb_drained("stop_tick");
    endtask

    task automatic test_stop_restart_reset();
        do_reset();
        gate_ms = 16'd3;
        open_window(4, 16'd0);
        for (int w = 1; w <= 4; w++) run_window(3, 4, 16'(w));
        idle(3);
        tick();
        enable = 1'b0;
        step();
        tests++;
        if (gate_open !== 1'b0 || latch !== 1'b0 || window_id !== 16'd4) begin
            fails++;
            $display("FAIL stop got open=%b latch=%b id=%0d required 0 0 4", gate_open, latch, window_id);
        end
        for (int i = 0; i < 3; i++) begin
            idle(3);
            tick();
        end
        tests++;
        if (overrun !== 1'b1 || window_id !== 16'd4 || gate_open !== 1'b0) begin
            fails++;
            $display("FAIL stopped got ovr=%b id=%0d open=%b required 1 4 0", overrun, window_id, gate_open);
        end
        enable = 1'b1;
        step();
        tests++;
        if (overrun !== 1'b0 || gate_open !== 1'b0 || clear !== 1'b0) begin
            fails++;
            $display("FAIL reenable got ovr=%b open=%b clear=%b required 0 0 0", overrun, gate_open, clear);
        end
        idle(3);
        tick();
        tests++;
        if (clear !== 1'b1 || gate_open !== 1'b1 || latch !== 1'b0 || window_id !== 16'd4) begin
            fails++;
            $display("FAIL realign got clear=%b open=%b latch=%b id=%0d required 1 1 0 4",
                     clear, gate_open, latch, window_id);
        end
        run_window(3, 4, 16'd5);
        idle(3);
        tick();
        #2;
        RST_N = 1'b0;
        #1;
        tests++;
        if (gate_open !== 1'b0 || clear !== 1'b0 || latch !== 1'b0 || overrun !== 1'b0 ||
            window_id !== 16'd0 || rif.report_req !== 1'b0 || rif.report_id !== 16'd0) begin
            fails++;
            $display("FAIL async_reset got open=%b clear=%b latch=%b ovr=%b id=%0d req=%b rid=%0d required all 0",
                     gate_open, clear, latch, overrun, window_id, rif.report_req, rif.report_id);
        end
        idle(2);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (clear !== 1'b0 || latch !== 1'b0 || gate_open !== 1'b0) begin
                fails++;
                $display("FAIL release_strobe i=%0d got clear=%b latch=%b open=%b required 0 0 0",
                         i, clear, latch, gate_open);
            end
        end
        sb_drained("stop_restart");
    endtask

    initial begin
        rif.report_ack = 1'b0;
        test_reset();
        test_basic();
        test_gate_zero();
        test_gate_change();
        test_overrun();
        test_ack_with_latch();
        test_stop_on_tick();
        test_stop_restart_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
